// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
//   Shared definitions for the SRAM arbiter client blocks (stream reader,
//   result writer).
//   Contents:
//     DEFAULT_ADDR_WIDTH / DEFAULT_DATA_WIDTH  arbiter word address/data widths
//     state_t                                  transfer FSM state encoding
//     occ_bits()                               width needed to hold 0..depth
// -----------------------------------------------------------------------------
package sram_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 20;
  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // Occupancy counters must represent the value 'depth' itself, hence +1.
  function automatic int occ_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock show-ahead FIFO. The head word is visible on head_data as soon
//   as it is written, so a valid/ready stream can be driven straight from it.
//   Ports:
//     clock, reset_n  clock and asynchronous active-low reset (pointers/count)
//     clear           synchronous flush; wins over push and pop
//     push, push_data write one word (dropped when full unless popping too)
//     pop             remove the head word (ignored when empty)
//     head_data       oldest word, forced to 0 while empty
//     count           words held, 0..FIFO_DEPTH
//     empty, full     occupancy flags
//   FIFO_DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         head_data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          empty,
  output logic                          full
);

  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH:0]   CNT_ONE = (PTR_WIDTH + 1)'(1);
  localparam logic [PTR_WIDTH:0]   CNT_MAX = (PTR_WIDTH + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_reg;
  logic [PTR_WIDTH-1:0]  rd_ptr_reg;
  logic [PTR_WIDTH:0]    count_reg;
  logic                  do_push;
  logic                  do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_MAX);
  assign count = count_reg;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);

  assign head_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clock) begin
    if (do_push && !clear) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/sram_stream_reader.sv
// -----------------------------------------------------------------------------
// sram_stream_reader
//   Avalon-MM read master on the test-runner port of the SRAM arbiter. Fetches
//   word_count consecutive words starting at base_addr with pipelined reads and
//   delivers them, in order, as a valid/ready stream.
//   Ports:
//     clock, reset_n                 clock, asynchronous active-low reset
//     start, abort                   command pulse / cancel request
//     base_addr, word_count          transfer descriptor (latched on start)
//     busy, done                     status; done pulses once per completed run
//     m_address .. m_writedata       Avalon-MM master request side
//     m_waitrequest, m_readdata,
//     m_readdataready                Avalon-MM slave response side
//     out_data, out_valid, out_ready output stream (FIFO head)
//   Every read in flight owns a reserved FIFO slot (credit check), so returning
//   data always has room regardless of how long the consumer stalls.
// -----------------------------------------------------------------------------
module sram_stream_reader
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] m_address,
  output logic [BE_WIDTH-1:0]   m_byteenable,
  output logic                  m_read,
  output logic                  m_write,
  output logic [DATA_WIDTH-1:0] m_writedata,
  input  logic                  m_waitrequest,
  input  logic [DATA_WIDTH-1:0] m_readdata,
  input  logic                  m_readdataready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int OCC_WIDTH = occ_bits(FIFO_DEPTH);
  localparam logic [OCC_WIDTH:0]    CREDIT_LIMIT = (OCC_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [OCC_WIDTH-1:0]  OCC_ONE      = OCC_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE      = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE     = ADDR_WIDTH'(1);

  state_t                state_reg;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [CNT_WIDTH-1:0]  count_reg;
  logic [CNT_WIDTH-1:0]  issued_reg;
  logic [CNT_WIDTH-1:0]  rcv_reg;
  logic [OCC_WIDTH-1:0]  outstanding_reg;
  logic                  done_reg;

  logic                  start_ok;
  logic                  accept;
  logic                  rdv;
  logic                  issue_left;
  logic                  last_issue;
  logic                  credit_ok;
  logic [OCC_WIDTH:0]    in_use;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_clear;
  logic [OCC_WIDTH-1:0]  fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  // abort has priority over start, and start is only honoured while idle.
  assign start_ok = start & ~abort & (state_reg == IDLE);
  assign accept   = m_read & ~m_waitrequest;
  // A return with nothing outstanding is a slave protocol error; drop it.
  assign rdv      = m_readdataready & (outstanding_reg != '0);

  assign issue_left = (issued_reg != count_reg);
  assign last_issue = accept & ((issued_reg + CNT_ONE) == count_reg);

  // Reads in flight plus words already buffered must leave a free slot.
  assign in_use    = {1'b0, outstanding_reg} + {1'b0, fifo_count};
  assign credit_ok = (in_use < CREDIT_LIMIT);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        // A zero-length request completes from IDLE without ever going busy.
        if (start_ok && (word_count != '0)) state_next = ISSUE;
      end
      ISSUE: begin
        if (abort)           state_next = FLUSH;
        else if (last_issue) state_next = DRAIN;
      end
      DRAIN: begin
        if (abort)                                       state_next = FLUSH;
        else if ((rcv_reg == count_reg) && fifo_empty)   state_next = IDLE;
      end
      FLUSH: begin
        // Stay until every accepted read has come back and been discarded.
        if (outstanding_reg == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy         = (state_reg != IDLE);
    m_read       = 1'b0;
    m_byteenable = '0;
    // abort masks the request combinationally so no read slips out after it.
    if ((state_reg == ISSUE) && !abort && issue_left && credit_ok) begin
      m_read       = 1'b1;
      m_byteenable = '1;
    end
  end

  assign m_address   = addr_reg;
  assign m_write     = 1'b0;
  assign m_writedata = '0;
  assign done        = done_reg;

  // ---------------------------------------------------------------------------
  // Address / issue / receive / outstanding counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_reg   <= '0;
      count_reg  <= '0;
      issued_reg <= '0;
      rcv_reg    <= '0;
    end else if (start_ok) begin
      addr_reg   <= base_addr;
      count_reg  <= word_count;
      issued_reg <= '0;
      rcv_reg    <= '0;
    end else begin
      // addr_reg only moves on accept, so it is stable across waitrequest.
      if (accept) begin
        addr_reg   <= addr_reg + ADDR_ONE;
        issued_reg <= issued_reg + CNT_ONE;
      end
      if (rdv) rcv_reg <= rcv_reg + CNT_ONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outstanding_reg <= '0;
    end else begin
      case ({accept, rdv})
        2'b10:   outstanding_reg <= outstanding_reg + OCC_ONE;
        2'b01:   outstanding_reg <= outstanding_reg - OCC_ONE;
        default: outstanding_reg <= outstanding_reg;
      endcase
    end
  end

  // done: either a zero-length start or the normal DRAIN -> IDLE exit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= (start_ok && (word_count == '0)) ||
                  ((state_reg == DRAIN) && (state_next == IDLE));
    end
  end

  // ---------------------------------------------------------------------------
  // Return buffer
  // ---------------------------------------------------------------------------
  // Clearing on the abort edge itself means the stream goes quiet immediately
  // and a word returning in that same cycle is dropped as well.
  assign fifo_clear = (state_next == FLUSH);
  assign fifo_push  = rdv & (state_next != FLUSH);
  assign fifo_pop   = out_valid & out_ready;
  assign out_valid  = ~fifo_empty;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_return_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (m_readdata),
    .pop       (fifo_pop),
    .head_data (out_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (reset_n) begin
      assert (!(m_readdataready && (outstanding_reg == '0)))
        else $error("sram_stream_reader: readdataready with no read outstanding");
      assert (!(fifo_push && fifo_full && !fifo_pop))
        else $error("sram_stream_reader: return buffer overrun");
    end
  end
`endif

endmodule

// File: tb/tb_sram_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_sram_stream_reader
//   Directed bench: an Avalon slave with fixed 2-cycle read latency and a
//   programmable waitrequest stall, a negedge monitor logging accepts, pops and
//   done pulses, and a linear sequence of directed transfers.
// -----------------------------------------------------------------------------
module tb_sram_stream_reader;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int CW = 16;
  localparam int FD = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic          out_ready = 1'b1;

  logic          busy;
  logic          done;
  logic [AW-1:0] m_address;
  logic [BW-1:0] m_byteenable;
  logic          m_read;
  logic          m_write;
  logic [DW-1:0] m_writedata;
  logic          m_waitrequest;
  logic [DW-1:0] m_readdata;
  logic          m_readdataready;
  logic [DW-1:0] out_data;
  logic          out_valid;

  always #5 clock = ~clock;

  sram_stream_reader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BE_WIDTH   (BW),
    .CNT_WIDTH  (CW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .base_addr       (base_addr),
    .word_count      (word_count),
    .busy            (busy),
    .done            (done),
    .m_address       (m_address),
    .m_byteenable    (m_byteenable),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdataready (m_readdataready),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready)
  );

  // Memory contents seen by the slave.
  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  // ---------------------------------------------------------------------------
  // Slave: waitrequest while addressing stall_addr for stall_len cycles,
  // data returned 2 cycles after accept.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] stall_addr = '0;
  int            stall_len  = 0;
  int            stall_cnt;
  logic          s_acc, s_wait;
  logic [AW-1:0] s_addr;
  logic          p1_v, p2_v;
  logic [AW-1:0] p1_a, p2_a;

  assign m_waitrequest   = m_read && (m_address == stall_addr) && (stall_cnt < stall_len);
  assign m_readdataready = p2_v;
  assign m_readdata      = p2_v ? mem_f(p2_a) : '0;

  always @(negedge clock) begin
    s_acc  = m_read && !m_waitrequest;
    s_wait = m_read && m_waitrequest;
    s_addr = m_address;
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p1_v <= 1'b0; p2_v <= 1'b0; p1_a <= '0; p2_a <= '0; stall_cnt <= 0;
    end else begin
      p1_v <= s_acc; p1_a <= s_addr;
      p2_v <= p1_v;  p2_a <= p1_a;
      if (s_wait) stall_cnt <= stall_cnt + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor (negedge: values that the next posedge will act on)
  // ---------------------------------------------------------------------------
  int            cyc = 0;
  logic [AW-1:0] acc_q[$];
  int            acc_cyc[$];
  logic [DW-1:0] pop_q[$];
  int            done_cnt = 0, done_busy_bad = 0, hold_viol = 0, busy_seen = 0;
  logic          prev_wait = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clock) begin
    cyc++;
    if (reset_n) begin
      if (m_read === 1'b1 && m_waitrequest === 1'b0) begin
        acc_q.push_back(m_address);
        acc_cyc.push_back(cyc);
      end
      if (out_valid === 1'b1 && out_ready) pop_q.push_back(out_data);
      if (done === 1'b1) begin
        done_cnt++;
        if (busy !== 1'b0) done_busy_bad++;
      end
      if (busy === 1'b1) busy_seen++;
      if (prev_wait && !(m_read === 1'b1 && m_address == prev_addr)) hold_viol++;
      prev_wait = (m_read === 1'b1) && (m_waitrequest === 1'b1);
      prev_addr = m_address;
    end else begin
      prev_wait = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    acc_q.delete(); acc_cyc.delete(); pop_q.delete();
    done_cnt = 0; done_busy_bad = 0; hold_viol = 0; busy_seen = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    #1;
    check("rst_busy",       busy, 0);
    check("rst_m_read",     m_read, 0);
    check("rst_done",       done, 0);
    check("rst_out_valid",  out_valid, 0);
    check("rst_m_address",  m_address, 0);
    check("rst_byteenable", m_byteenable, 0);
    check("rst_out_data",   out_data, 0);
    check("rst_write",      {m_write, m_writedata}, 0);
    repeat (2) tick();
    clear_logs();
    stall_len = 0; stall_addr = '0; out_ready = 1'b1;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic start_xfer(input logic [AW-1:0] b, input logic [CW-1:0] c);
    base_addr = b; word_count = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check("done_within_budget", done_cnt != 0, 1);
  endtask

  task automatic check_stream(input string name, input logic [AW-1:0] b, input int cnt);
    logic [AW-1:0] ea;
    check({name, "_accepts"}, acc_q.size(), cnt);
    check({name, "_words"},   pop_q.size(), cnt);
    for (int i = 0; i < cnt; i++) begin
      ea = b + AW'(i);
      if (i < acc_q.size()) check($sformatf("%s_addr%0d", name, i), acc_q[i], ea);
      if (i < pop_q.size()) check($sformatf("%s_data%0d", name, i), pop_q[i], mem_f(ea));
    end
    $display("%s: base=%05h count=%0d accepted=%0d delivered=%0d done=%0d",
             name, b, cnt, acc_q.size(), pop_q.size(), done_cnt);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    tick();
    do_reset();

    // 1: four back-to-back reads
    start_xfer(20'h00010, 16'd4);
    wait_done(100);
    repeat (3) tick();
    check_stream("t1", 20'h00010, 4);
    check("t1_consecutive", (acc_cyc.size() == 4) ? (acc_cyc[3] - acc_cyc[0]) : -1, 3);
    check("t1_done_once", done_cnt, 1);
    check("t1_busy_low_at_done", done_busy_bad, 0);
    check("t1_was_busy", busy_seen > 0, 1);
    check("t1_idle_busy", busy, 0);

    // 2: 3-cycle waitrequest on the second read
    do_reset();
    stall_addr = 20'h00011; stall_len = 3;
    start_xfer(20'h00010, 16'd4);
    wait_done(100);
    repeat (3) tick();
    check_stream("t2", 20'h00010, 4);
    check("t2_addr_held", hold_viol, 0);
    check("t2_stall_cycles", stall_cnt, 3);
    check("t2_done_once", done_cnt, 1);

    // 3: credit limit with a stalled consumer, stray start ignored
    do_reset();
    out_ready = 1'b0;
    start_xfer(20'h00200, 16'd20);
    repeat (20) tick();
    check("t3_accepts_at_limit", acc_q.size(), 8);
    check("t3_read_stopped", m_read, 0);
    check("t3_head_valid", out_valid, 1);
    check("t3_head_data", out_data, mem_f(20'h00200));
    start_xfer(20'h00300, 16'd2);
    tick();
    check("t3_still_busy", busy, 1);
    out_ready = 1'b1;
    wait_done(300);
    repeat (3) tick();
    check_stream("t3", 20'h00200, 20);
    check("t3_done_once", done_cnt, 1);

    // 4: address wrap
    do_reset();
    start_xfer(20'hFFFFE, 16'd4);
    wait_done(100);
    repeat (3) tick();
    check_stream("t4", 20'hFFFFE, 4);

    // 5: zero-length request
    do_reset();
    base_addr = 20'h00055; word_count = 16'd0; start = 1'b1;
    @(negedge clock);
    check("t5_done_not_yet", done, 0);
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    check("t5_done_pulse", done, 1);
    check("t5_busy_low", busy, 0);
    @(negedge clock);
    check("t5_done_one_cycle", done, 0);
    repeat (4) tick();
    check("t5_no_reads", acc_q.size(), 0);
    check("t5_never_busy", busy_seen, 0);
    check("t5_done_count", done_cnt, 1);

    // 6: abort after 3 accepts, 2 reads still in flight
    do_reset();
    out_ready = 1'b0;
    start_xfer(20'h00400, 16'd8);
    begin
      int n = 0;
      while (acc_q.size() < 3 && n < 50) begin
        tick();
        n++;
      end
    end
    check("t6_three_accepts_seen", acc_q.size(), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    check("t6_no_new_reads", acc_q.size(), 3);
    check("t6_nothing_streamed", pop_q.size(), 0);
    check("t6_fifo_empty", out_valid, 0);
    check("t6_idle", busy, 0);
    check("t6_no_done", done_cnt, 0);
    $display("t6: abort after %0d accepts, delivered=%0d done=%0d", acc_q.size(), pop_q.size(), done_cnt);
    clear_logs();
    start_xfer(20'h00500, 16'd2);
    wait_done(100);
    repeat (3) tick();
    check_stream("t6b", 20'h00500, 2);

    // start together with abort: abort wins
    clear_logs();
    base_addr = 20'h00700; word_count = 16'd3; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (6) tick();
    check("t7_no_reads", acc_q.size(), 0);
    check("t7_never_busy", busy_seen, 0);
    check("t7_no_done", done_cnt, 0);
    $display("t7: start+abort accepted=%0d busy_cycles=%0d", acc_q.size(), busy_seen);

    // reset in the middle of a transfer (do_reset checks outputs right after assertion)
    out_ready = 1'b0;
    start_xfer(20'h00600, 16'd10);
    repeat (3) tick();
    check("t8_busy_before_reset", busy, 1);
    do_reset();
    check("t8_idle_after_reset", busy, 0);
    $display("t8: reset mid-transfer, busy=%0b", busy);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
